systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Edge injector for the systolic array: the transmitter side of the matrix_data_t {data, last} stream that each PE consumes on its a/b inputs.
- Accepts one N-element operand vector per k-step through a valid/ready handshake and drives N lanes into the array edge.
- Lane i is delayed by i cycles (diagonal skew), and last is set on the final k-step so each PE drains and clears its accumulator.
- Two instances are used per array: one for the A edge (rows) and one for the B edge (columns).

Parameters:
- N, 4, number of lanes (array dimension).
- K_MAX, 16, maximum k-length per tile.
- K_WIDTH, $clog2(K_MAX+1), width of the k-length and beat counter.
- DATA_WIDTH comes from pe_pkg; it is not a parameter of this block.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start a tile; sampled in IDLE only.
- k_len_i  in  K_WIDTH  tile k-length; latched on start.
- vec_valid_i  in  1  operand vector valid.
- vec_ready_o  out  1  feeder accepts a vector this cycle.
- vec_data_i  in  N*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- lane_o  out  N x matrix_data_t  skewed streams to the array edge.
- busy_o  out  1  high in STREAM and FLUSH.
- done_o  out  1  one-cycle pulse when lane N-1 presents last.

Behaviour:
- Reset (async assert, any state):
  - FSM goes to IDLE; beat and flush counters clear; every skew register clears.
  - Outputs: lane_o all {data 0, last 0}; vec_ready_o=0; busy_o=0; done_o=0.
  - In-flight tile is discarded.
  - Deassertion is synchronised externally.
- FSM states:
  - IDLE -> STREAM when start_i=1 and k_len_i!=0. K and beat_cnt=0 are latched.
  - IDLE with start_i=1 and k_len_i=0, or k_len_i>K_MAX: ignored, stays IDLE.
  - STREAM -> FLUSH on the edge that accepts beat K-1.
  - FLUSH -> IDLE after N-1 further cycles, on the edge ending the done_o cycle. N=1 goes straight from STREAM to IDLE with done_o in the next cycle.
- Handshake:
  - vec_ready_o=1 only in STREAM; it is a pure function of state.
  - A beat is accepted when vec_valid_i & vec_ready_o.
  - vec_valid_i in IDLE or FLUSH is not accepted and has no effect.
  - start_i outside IDLE is ignored.
- Injection:
  - Each STREAM cycle pushes one entry into the lane-0 stage.
  - Accepted beat: entry is {vec_data_i lane i, last = (beat_cnt==K-1)}.
  - No beat accepted: bubble {0, 0}. Bubbles add 0*0 in the PE, so results are unaffected.
  - FLUSH cycles push bubbles.
- Skew and latency:
  - Lane i has i+1 register stages.
  - An entry pushed at edge t appears on lane_o[0] in cycle t+1 and on lane_o[i] in cycle t+1+i.
  - All lanes see an identical bubble pattern.
- done_o:
  - Registered; high exactly in the cycle lane_o[N-1].last=1; never asserted otherwise.
  - The next start_i is accepted the cycle after done_o.
- Width: beat_cnt saturates at K-1 by construction; no wrap-around is possible within a tile.
- All outputs are registered; there are no combinational paths from input to lane_o.

Decomposition:
- pe_pkg (existing) supplies matrix_data_t and DATA_WIDTH.
- Add to pe_pkg: feeder_state_e {IDLE, STREAM, FLUSH}.
- Sub-module skew_delay_line (parameter DEPTH, matrix_data_t in/out, async active-low reset), generated once per lane with DEPTH=i+1.
- FSM and counters stay in systolic_feeder.

Test Plan:
- Continuous stream: N=4, K=3, start at cycle 0; vectors {1,2,3,4},{5,6,7,8},{9,10,11,12} accepted at cycles 1-3.
  - lane_o[0] = 1,5,9 in cycles 2-4, last on 9.
  - lane_o[3] = 4,8,12 in cycles 5-7, last on 12.
  - done_o pulses in cycle 7 only; busy_o high cycles 1-7.
- Bubbles: same tile with vec_valid_i low in cycle 2.
  - Every lane shows a {0,0} entry between values 1 and 5 at its own skew offset; done_o moves one cycle later.
  - Summed products in a downstream pe column match the no-bubble run.
- Edge k-lengths:
  - start_i with k_len_i=0: busy_o stays 0 and vec_ready_o stays 0.
  - K=1 with vector {7,7,7,7}: each lane carries 7 with last=1; done_o pulses 4 cycles after acceptance.
- Async reset mid-tile: drop rst_ni between clock edges during STREAM with beat 1 accepted.
  - lane_o, busy_o and vec_ready_o go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh K=2 tile completes correctly.
- Protocol illegality:
  - start_i pulsed during STREAM and FLUSH: K is unchanged and no restart occurs.
  - vec_valid_i held high in IDLE: vec_ready_o=0 and no entries are injected.
- Back-to-back tiles: start_i asserted the cycle after done_o with K=2. The second tile's first value appears on lane_o[0] two cycles later, and no stale last appears.

Source files
------------

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types for the processing-element array and its edge
//                feeders: operand width, the {data, last} stream element and
//                the feeder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

  localparam int DATA_WIDTH = 8;

  // One element of the operand stream consumed on a PE a/b input. A set
  // last bit tells the PE this is the final k-step of the tile.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } matrix_data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : DEPTH-stage register pipeline for matrix_data_t elements.
//                Used once per feeder lane to build the diagonal skew.
//  Ports       : clk_i  - clock
//                rst_ni - asynchronous active-low reset, clears every stage
//                in_i   - element captured into stage 0 each cycle
//                out_o  - element leaving the last stage
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line
  import pe_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  matrix_data_t in_i,
  output matrix_data_t out_o
);

  matrix_data_t [DEPTH-1:0] stage_q;
  matrix_data_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in_i;
    for (int s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feeder
//  Description : Edge injector for the systolic array. Accepts one N-element
//                operand vector per k-step and drives N diagonally skewed
//                {data, last} lanes into the array edge; lane i lags lane 0
//                by i cycles. last marks the final k-step of the tile.
//  Ports       : clk_i        - clock
//                rst_ni       - asynchronous active-low reset
//                start_i      - start a tile (honoured in IDLE only)
//                k_len_i      - tile k-length, latched on start
//                vec_valid_i  - operand vector valid
//                vec_ready_o  - vector accepted this cycle when valid
//                vec_data_i   - lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//                lane_o       - skewed streams to the array edge
//                busy_o       - tile in progress (STREAM or FLUSH)
//                done_o       - one-cycle pulse when lane N-1 carries last
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder
  import pe_pkg::*;
#(
  parameter int N       = 4,
  parameter int K_MAX   = 16,
  parameter int K_WIDTH = $clog2(K_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [K_WIDTH-1:0]      k_len_i,
  input  logic                    vec_valid_i,
  output logic                    vec_ready_o,
  input  logic [N*DATA_WIDTH-1:0] vec_data_i,
  output matrix_data_t [N-1:0]    lane_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_STREAM = STREAM;
  localparam logic [1:0] S_FLUSH  = FLUSH;

  localparam int                 FL_WIDTH = (N > 1) ? $clog2(N) : 1;
  localparam logic [FL_WIDTH-1:0] FL_LAST = FL_WIDTH'(N - 1);
  localparam logic [K_WIDTH-1:0]  K_LIMIT = K_WIDTH'(K_MAX);

  logic [1:0]          state_q,     state_d;
  logic [K_WIDTH-1:0]  k_q,         k_d;
  logic [K_WIDTH-1:0]  beat_cnt_q,  beat_cnt_d;
  logic [FL_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic                 beat_last;
  matrix_data_t [N-1:0] inject;

  assign beat_last = (beat_cnt_q == (k_q - K_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    inject      = '0;  // bubble unless a beat is accepted this cycle

    case (state_q)
      S_IDLE: begin
        // Zero-length and oversized tiles are dropped silently.
        if (start_i && (k_len_i != '0) && (k_len_i <= K_LIMIT)) begin
          state_d    = S_STREAM;
          k_d        = k_len_i;
          beat_cnt_d = '0;
        end
      end

      S_STREAM: begin
        if (vec_valid_i) begin
          for (int i = 0; i < N; i++) begin
            inject[i].data = vec_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            inject[i].last = beat_last;
          end
          if (beat_last) begin
            // Single-lane arrays need no flush: the last entry is already
            // on the only lane in the following cycle.
            state_d     = (N == 1) ? S_IDLE : S_FLUSH;
            flush_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
          end
        end
      end

      S_FLUSH: begin
        // N flush cycles; the final one is the cycle lane N-1 shows last.
        if (flush_cnt_q == FL_LAST) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_WIDTH'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH (i + 1)
    ) u_skew (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .in_i   (inject[i]),
      .out_o  (lane_o[i])
    );
  end

  assign vec_ready_o = (state_q == S_STREAM);
  assign busy_o      = (state_q != S_IDLE);
  // last appears exactly once per tile on lane N-1, straight from a flop.
  assign done_o      = lane_o[N-1].last;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_feeder
//  Description : Randomised self-checking bench for systolic_feeder with a
//                timestamped scoreboard fed by a behavioural tile model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;
  import pe_pkg::*;

  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int K_W   = $clog2(K_MAX + 1);
  localparam int DW    = DATA_WIDTH;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b1;
  logic                 start_i = 1'b0;
  logic [K_W-1:0]       k_len_i = '0;
  logic                 vec_valid_i = 1'b0;
  logic                 vec_ready_o;
  logic [N*DW-1:0]      vec_data_i = '0;
  matrix_data_t [N-1:0] lane_o;
  logic                 busy_o;
  logic                 done_o;

  systolic_feeder #(.N(N), .K_MAX(K_MAX), .K_WIDTH(K_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .k_len_i     (k_len_i),
    .vec_valid_i (vec_valid_i),
    .vec_ready_o (vec_ready_o),
    .vec_data_i  (vec_data_i),
    .lane_o      (lane_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct {
    int            c;
    logic [DW-1:0] data;
    logic          last;
  } lane_exp_t;

  typedef struct {
    int   c;
    logic ready;
    logic busy;
  } ctl_exp_t;

  lane_exp_t lane_q [N][$];
  ctl_exp_t  ctl_q[$];
  int        done_q[$];

  // ---------------- behavioural tile model ----------------
  // A tile streams from the cycle after an accepted start until K beats are
  // taken; beat accepted in cycle c shows on lane i in cycle c+1+i; done is
  // the cycle lane N-1 shows the final beat; busy spans stream start..done.
  bit m_stream   = 0;
  int m_k        = 0;
  int m_beats    = 0;
  int m_busy_end = -1;

  logic [N*DW-1:0] vec_src[$];   // directed vectors, consumed in order
  bit              valid_pat[$]; // directed valid pattern for stream cycles

  task automatic model_clear();
    m_stream = 0; m_k = 0; m_beats = 0; m_busy_end = -1;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    ctl_q.delete();
    done_q.delete();
  endtask

  function automatic bit model_idle(input int c);
    return !m_stream && (c > m_busy_end);
  endfunction

  task automatic drive_cycle(input bit st, input int kl, input bit v,
                             input logic [N*DW-1:0] d, output bit acc);
    int c;
    ctl_exp_t e;
    lane_exp_t le;
    c = cyc;
    acc = 0;
    start_i = st; k_len_i = K_W'(kl); vec_valid_i = v; vec_data_i = d;
    e.c = c; e.ready = m_stream; e.busy = m_stream || (c <= m_busy_end);
    ctl_q.push_back(e);
    if (m_stream && v) begin
      acc = 1;
      for (int i = 0; i < N; i++) begin
        le.c = c + 1 + i;
        le.data = d[i*DW +: DW];
        le.last = (m_beats == m_k - 1);
        lane_q[i].push_back(le);
      end
      if (m_beats == m_k - 1) begin
        m_stream = 0;
        m_busy_end = c + N;
        done_q.push_back(c + N);
      end else begin
        m_beats++;
      end
    end else if (model_idle(c) && st && kl >= 1 && kl <= K_MAX) begin
      m_stream = 1; m_k = kl; m_beats = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit st, input int kl, input bit idle_v);
    bit acc;
    for (int j = 0; j < n; j++) begin
      tick();
      drive_cycle(st, kl, idle_v ? 1'($urandom_range(1)) : 1'b0, $urandom, acc);
    end
  endtask

  // One tile: pre idle cycles, a start, then stream/flush until the model
  // reports the tile finished. jpct = chance of a stray start mid-tile.
  task automatic run_tile(input int k, input int pre, input int vpct,
                          input int jpct, input bit idle_v);
    bit acc, v, st;
    logic [N*DW-1:0] d;
    int guard;
    idle_cycles(pre, 1'b0, 0, idle_v);
    tick();
    drive_cycle(1'b1, k, idle_v ? 1'($urandom_range(1)) : 1'b0, $urandom, acc);
    guard = 0;
    while (!model_idle(cyc + 1) && guard < 300) begin
      tick();
      guard++;
      if (m_stream && valid_pat.size() > 0) v = valid_pat.pop_front();
      else v = ($urandom_range(99) < vpct);
      d = (m_stream && v && vec_src.size() > 0) ? vec_src[0] : N*DW'($urandom);
      st = ($urandom_range(99) < jpct);
      drive_cycle(st, $urandom_range(1, K_MAX), v, d, acc);
      if (acc && vec_src.size() > 0) void'(vec_src.pop_front());
    end
    chk("tile_guard", guard < 300, 1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (rst_ni) begin
      while (ctl_q.size() > 0 && ctl_q[0].c < cyc) begin
        chk("ctl_missed", ctl_q[0].c, cyc);
        void'(ctl_q.pop_front());
      end
      if (ctl_q.size() > 0 && ctl_q[0].c == cyc) begin
        chk("vec_ready_o", vec_ready_o, ctl_q[0].ready);
        chk("busy_o", busy_o, ctl_q[0].busy);
        void'(ctl_q.pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (lane_q[i].size() > 0 && lane_q[i][0].c == cyc) begin
          chk($sformatf("lane%0d_data", i), lane_o[i].data, lane_q[i][0].data);
          chk($sformatf("lane%0d_last", i), lane_o[i].last, lane_q[i][0].last);
          void'(lane_q[i].pop_front());
        end else begin
          chk($sformatf("lane%0d_bubble", i), lane_o[i], '0);
        end
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        chk("done_o", done_o, 1);
        void'(done_q.pop_front());
      end else begin
        chk("done_o_idle", done_o, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_lanes", lane_o, '0);
    chk("rst_ready", vec_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    #21 rst_ni = 1'b1;

    // continuous stream K=3
    vec_src.push_back({8'd4, 8'd3, 8'd2, 8'd1});
    vec_src.push_back({8'd8, 8'd7, 8'd6, 8'd5});
    vec_src.push_back({8'd12, 8'd11, 8'd10, 8'd9});
    run_tile(3, 1, 100, 0, 1'b0);

    // same tile with a bubble in the second stream cycle
    vec_src.push_back({8'd4, 8'd3, 8'd2, 8'd1});
    vec_src.push_back({8'd8, 8'd7, 8'd6, 8'd5});
    vec_src.push_back({8'd12, 8'd11, 8'd10, 8'd9});
    valid_pat.push_back(1'b1);
    valid_pat.push_back(1'b0);
    valid_pat.push_back(1'b1);
    valid_pat.push_back(1'b1);
    run_tile(3, 2, 100, 0, 1'b0);

    // zero-length and oversized starts are ignored; valid in idle has no effect
    idle_cycles(1, 1'b1, 0, 1'b1);
    idle_cycles(4, 1'b0, 0, 1'b1);
    idle_cycles(1, 1'b1, K_MAX + 1, 1'b1);
    idle_cycles(4, 1'b0, 0, 1'b1);

    // K=1
    vec_src.push_back({8'd7, 8'd7, 8'd7, 8'd7});
    run_tile(1, 1, 100, 0, 1'b0);

    // stray starts during stream and flush, then back-to-back K=2
    run_tile(5, 1, 80, 60, 1'b1);
    run_tile(2, 0, 100, 0, 1'b0);
    run_tile(2, 0, 100, 0, 1'b0);

    // asynchronous reset mid-tile after beat 1 accepted
    tick(); drive_cycle(1'b1, 4, 1'b0, '0, acc);
    tick(); drive_cycle(1'b0, 0, 1'b1, {8'h14, 8'h13, 8'h12, 8'h11}, acc);
    tick(); drive_cycle(1'b0, 0, 1'b1, {8'h24, 8'h23, 8'h22, 8'h21}, acc);
    tick();
    start_i = 0; vec_valid_i = 0; k_len_i = '0; vec_data_i = '0;
    #2 rst_ni = 1'b0;
    model_clear();
    #1;
    chk("arst_lanes", lane_o, '0);
    chk("arst_ready", vec_ready_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    run_tile(2, 1, 100, 0, 1'b0);

    // randomised tiles
    for (int t = 0; t < 40; t++) begin
      run_tile($urandom_range(1, K_MAX), $urandom_range(0, 3),
               $urandom_range(40, 100), $urandom_range(0, 30), 1'($urandom_range(1)));
    end

    idle_cycles(N + 3, 1'b0, 0, 1'b1);
    @(negedge clk_i);
    #1;
    chk("ctl_q_empty", ctl_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    for (int i = 0; i < N; i++) chk($sformatf("lane%0d_q_empty", i), lane_q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
